// File: rtl/gate_bist_pkg.sv
// rtl/gate_bist_pkg.sv - shared states, gate ops and golden reference for the gate BIST controller
package gate_bist_pkg;

  typedef enum logic [2:0] {IDLE, APPLY, SETTLE, CHECK, DONE} bist_state_t;
  typedef enum logic [1:0] {OP_AND, OP_OR, OP_XOR, OP_NAND} gate_op_t;

  localparam int MAX_N_IN = 8;

  // Reduction over the low n_in bits only; unused upper bits are masked to the identity value.
  function automatic logic golden(gate_op_t op, logic [MAX_N_IN-1:0] vec, int unsigned n_in);
    logic [MAX_N_IN-1:0] mask;
    logic                res;
    mask = MAX_N_IN'((16'h1 << n_in) - 16'h1);
    case (op)
      OP_AND:  res = &(vec | ~mask);
      OP_OR:   res = |(vec & mask);
      OP_XOR:  res = ^(vec & mask);
      default: res = ~&(vec | ~mask);
    endcase
    return res;
  endfunction

endpackage

// File: rtl/gate_bist_if.sv
// rtl/gate_bist_if.sv - run control, result and gate-side signals of the gate BIST controller
interface gate_bist_if
  import gate_bist_pkg::*;
#(
  parameter int N_IN = 2
);
  logic            start;
  gate_op_t        op;
  logic [N_IN-1:0] dut_in;
  logic            dut_out;
  logic            busy;
  logic            done;
  logic            pass;
  logic [N_IN:0]   err_count;
  logic [N_IN-1:0] first_fail_vec;
  logic            fail_seen;

  modport master (
    output start, op, dut_out,
    input  dut_in, busy, done, pass, err_count, first_fail_vec, fail_seen
  );

  modport slave (
    input  start, op, dut_out,
    output dut_in, busy, done, pass, err_count, first_fail_vec, fail_seen
  );
endinterface

// File: rtl/gate_bist_settle_cnt.sv
// rtl/gate_bist_settle_cnt.sv - loadable down-counter with zero flag timing the settle interval
module gate_bist_settle_cnt #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);
endmodule

// File: rtl/gate_bist_ctrl.sv
// rtl/gate_bist_ctrl.sv - exhaustive sweep tester for small combinational gates
// GATE_BIST_STOP_ON_FAIL_EN ends the sweep at the first mismatching vector.
module gate_bist_ctrl
  import gate_bist_pkg::*;
#(
  parameter int N_IN       = 2,
  parameter int SETTLE_CYC = 2
) (
  input logic       clk,
  input logic       rst_n,
  gate_bist_if.slave bus
);
  localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  bist_state_t     state, state_nxt;
  gate_op_t        op_q;
  logic [N_IN-1:0] vec;
  logic [N_IN-1:0] dut_in_q;
  logic [N_IN-1:0] ffv_q;
  logic [N_IN:0]   err_q;
  logic            busy_q, done_q, pass_q, fs_q;
  logic            expected, mismatch, last_vec, settle_zero;

  assign expected = golden(op_q, MAX_N_IN'(vec), N_IN);
  // Case inequality so an X/Z gate output is flagged rather than silently matching.
  assign mismatch = (bus.dut_out !== expected);
  assign last_vec = (vec == {N_IN{1'b1}});

  gate_bist_settle_cnt #(.W(CW)) u_settle_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (state == APPLY),
    .load_val (CW'(SETTLE_CYC - 1)),
    .dec      (state == SETTLE),
    .zero     (settle_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = APPLY;
      APPLY:   state_nxt = SETTLE;
      SETTLE:  if (settle_zero) state_nxt = CHECK;
`ifdef GATE_BIST_STOP_ON_FAIL_EN
      CHECK:   state_nxt = (last_vec || mismatch) ? DONE : APPLY;
`else
      CHECK:   state_nxt = last_vec ? DONE : APPLY;
`endif
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= OP_AND;
      vec      <= '0;
      dut_in_q <= '0;
      ffv_q    <= '0;
      err_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      fs_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            op_q   <= bus.op;
            vec    <= '0;
            ffv_q  <= '0;
            err_q  <= '0;
            fs_q   <= 1'b0;
            pass_q <= 1'b0;
            busy_q <= 1'b1;
          end
        end
        APPLY: dut_in_q <= vec;
        CHECK: begin
          if (mismatch) begin
            err_q <= err_q + 1'b1;
            if (!fs_q) begin
              ffv_q <= vec;
              fs_q  <= 1'b1;
            end
          end
          if (state_nxt == DONE) begin
            busy_q <= 1'b0;
          end else begin
            vec <= vec + 1'b1;
          end
        end
        DONE: begin
          done_q <= 1'b1;
          pass_q <= (err_q == '0);
        end
        default: ;
      endcase
    end
  end

  assign bus.dut_in         = dut_in_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.pass           = pass_q;
  assign bus.err_count      = err_q;
  assign bus.first_fail_vec = ffv_q;
  assign bus.fail_seen      = fs_q;
endmodule

// File: doc/gate_bist_ctrl.md
Name: gate_bist_ctrl

Overview:
- Synthesizable on-chip tester for small combinational gate modules such as two-input AND/OR/XOR/NAND cells.
- Sits on the input side of the gate: drives every input vector exhaustively, waits a settle interval, samples the gate output, and checks it against a golden function chosen by `op`.
- Reports a pass flag, an error count and the first failing vector, so a gate can be checked on the board as well as in simulation.

Parameters:
- N_IN, 2, number of gate inputs (1..8); vectors swept = 2**N_IN.
- SETTLE_CYC, 2, cycles between driving a vector and sampling `dut_out` (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  run request; sampled only in IDLE.
- op  in  2  golden function: 00 AND, 01 OR, 10 XOR, 11 NAND (reduction over all inputs).
- dut_in  out  N_IN  vector driven to the gate under test.
- dut_out  in  1  output of the gate under test.
- busy  out  1  high from the cycle after start is accepted through the last CHECK.
- done  out  1  one-cycle pulse at end of run.
- pass  out  1  1 when err_count==0 at end of run; held until next accepted start.
- err_count  out  N_IN+1  number of mismatching vectors in last/current run.
- first_fail_vec  out  N_IN  vector of first mismatch; 0 if none.
- fail_seen  out  1  sticky; a mismatch occurred in this run.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE; dut_in=0; busy=0; done=0; pass=0; err_count=0; first_fail_vec=0; fail_seen=0.
- States: IDLE, APPLY, SETTLE, CHECK, DONE.
- IDLE:
  - start=1 at an edge goes to APPLY.
  - On acceptance: vec=0; err_count=0; fail_seen=0; first_fail_vec=0; pass=0.
  - op is latched into op_q; op changes mid-run are ignored.
- APPLY (1 cycle): dut_in=vec; goes to SETTLE with settle counter=SETTLE_CYC-1.
- SETTLE (SETTLE_CYC cycles): counter decrements; at 0 goes to CHECK. dut_in is held stable.
- CHECK (1 cycle):
  - expected = golden(op_q, vec); compare against dut_out.
  - On mismatch: err_count+1. If fail_seen was 0, first_fail_vec=vec and fail_seen=1.
  - If vec == 2**N_IN-1, go to DONE; else vec+1 and go to APPLY.
- DONE (1 cycle):
  - done=1; pass=(err_count==0); busy=0.
  - Next state IDLE.
  - dut_in keeps the last vector until the next run.
- Timing:
  - Cycles per vector = SETTLE_CYC+2.
  - done is asserted (2**N_IN)*(SETTLE_CYC+2)+1 edges after the accepting edge.
- err_count width N_IN+1 holds the maximum 2**N_IN; no wrap and no saturation logic is needed.
- start while busy or in DONE is ignored (no queueing).
- start held high continuously restarts a new run the cycle after DONE.
- dut_out is treated as synchronous to clk. X or Z on dut_out counts as a mismatch in simulation (case inequality).
- Reset mid-run aborts immediately to the reset values. No done pulse is produced.

Optional Feature:
- Macro: GATE_BIST_STOP_ON_FAIL_EN.
- Defined: the first mismatch in CHECK goes directly to DONE. err_count=1 and pass=0; first_fail_vec captures the failing vector.
- Undefined: the sweep always runs all 2**N_IN vectors.

Decomposition:
- Package gate_bist_pkg:
  - typedef enum logic [2:0] bist_state_t {IDLE, APPLY, SETTLE, CHECK, DONE}.
  - typedef enum logic [1:0] gate_op_t {OP_AND, OP_OR, OP_XOR, OP_NAND}.
  - function golden(op, vec) returning the reduction result.
- One natural sub-module, gate_bist_settle_cnt: loadable down-counter with a zero flag, used by SETTLE.

Test Plan:
- N_IN=2, SETTLE_CYC=2, correct AND gate, op=00, one-cycle start pulse:
  - dut_in steps 00,01,10,11.
  - done pulses 17 edges after acceptance.
  - pass=1, err_count=0, first_fail_vec=00.
- Stuck-at-0 AND gate (dut_out=0), op=00: err_count=1, first_fail_vec=11, pass=0, fail_seen=1.
- Correct AND gate, op=10 (XOR expected):
  - Mismatches at 01, 10 and 11.
  - err_count=3, first_fail_vec=01, pass=0.
- start pulsed again while busy (e.g., at cycle 5): ignored; run completes at original cycle 17 with unchanged results.
- rst_n low at cycle 9 of a run:
  - All outputs go to reset values asynchronously; no done pulse.
  - A new start after release runs a full clean sweep.
- With GATE_BIST_STOP_ON_FAIL_EN, stuck-at-1 AND gate, op=00:
  - Fails at vector 00 in the first CHECK.
  - done pulses 5 edges after acceptance; err_count=1, first_fail_vec=00.
